// File: rtl/gemm_idx_gen.sv
// gemm_idx_gen: walks iter_out x iter_in x [uop_bgn, uop_end) for one GEMM
// instruction, fetching each uop and emitting acc/inp/wgt buffer indices.
// Optional feature macro: GEMM_IDX_BOUNDS_CHK_EN adds idx_err / err_insn_cnt.
module gemm_idx_gen #(
    parameter int unsigned UOP_WIDTH     = 32,
    parameter int unsigned UPC_WIDTH     = 13,
    parameter int unsigned INS_WIDTH     = 128,
    parameter int unsigned ITER_WIDTH    = 14,
    parameter int unsigned ACC_IDX_WIDTH = 11,
    parameter int unsigned INP_IDX_WIDTH = 11,
    parameter int unsigned WGT_IDX_WIDTH = 10,
    parameter int unsigned ACC_DEPTH_MAX = 2048,
    parameter int unsigned INP_DEPTH_MAX = 2048,
    parameter int unsigned WGT_DEPTH_MAX = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     insn_valid,
    output logic                     insn_ready,
    input  logic [INS_WIDTH-1:0]     insn,
    output logic [UPC_WIDTH-1:0]     upc,
    output logic                     uop_rd_en,
    input  logic [UOP_WIDTH-1:0]     uop,
    output logic                     idx_valid,
    input  logic                     idx_ready,
    output logic [ACC_IDX_WIDTH-1:0] acc_idx,
    output logic [INP_IDX_WIDTH-1:0] inp_idx,
    output logic [WGT_IDX_WIDTH-1:0] wgt_idx,
    output logic                     reset_acc,
    output logic                     idx_last,
`ifdef GEMM_IDX_BOUNDS_CHK_EN
    output logic                     idx_err,
    output logic [7:0]               err_insn_cnt,
`endif
    output logic                     done
);

    localparam int unsigned F_DST_OUT = 63;
    localparam int unsigned F_DST_IN  = F_DST_OUT + ACC_IDX_WIDTH;
    localparam int unsigned F_SRC_OUT = F_DST_IN + ACC_IDX_WIDTH;
    localparam int unsigned F_SRC_IN  = F_SRC_OUT + INP_IDX_WIDTH;
    localparam int unsigned F_WGT_OUT = F_SRC_IN + INP_IDX_WIDTH;
    localparam int unsigned F_WGT_IN  = F_WGT_OUT + WGT_IDX_WIDTH;
    localparam int unsigned F_TOP     = F_WGT_IN + WGT_IDX_WIDTH;

`ifdef GEMM_IDX_BOUNDS_CHK_EN
    // Offsets get headroom so the untruncated index is visible to the check.
    localparam int unsigned EXT = ITER_WIDTH + 2;
`else
    localparam int unsigned EXT = 0;
`endif
    localparam int unsigned ACC_OW = ACC_IDX_WIDTH + EXT;
    localparam int unsigned INP_OW = INP_IDX_WIDTH + EXT;
    localparam int unsigned WGT_OW = WGT_IDX_WIDTH + EXT;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EMIT, S_FIN} state_t;
    state_t state, state_nxt;

    logic [UPC_WIDTH-1:0]     bgn_q;
    logic [UPC_WIDTH:0]       end_q;
    logic [ITER_WIDTH-1:0]    iter_out_q, iter_in_q, i_out, i_in;
    logic [ACC_IDX_WIDTH-1:0] f_acc_out, f_acc_in;
    logic [INP_IDX_WIDTH-1:0] f_inp_out, f_inp_in;
    logic [WGT_IDX_WIDTH-1:0] f_wgt_out, f_wgt_in;
    logic [ACC_OW-1:0]        acc_base, acc_off, acc_sum;
    logic [INP_OW-1:0]        inp_base, inp_off, inp_sum;
    logic [WGT_OW-1:0]        wgt_base, wgt_off, wgt_sum;

    logic [UPC_WIDTH-1:0]  d_bgn;
    logic [UPC_WIDTH:0]    d_end;
    logic [ITER_WIDTH-1:0] d_out, d_in;
    logic accept, degenerate, last_upc, last_in, last_out, last_all;
    logic unused_insn_bits;

    assign d_bgn = UPC_WIDTH'(insn[20:8]);
    assign d_end = (UPC_WIDTH+1)'(insn[34:21]);
    assign d_out = ITER_WIDTH'(insn[48:35]);
    assign d_in  = ITER_WIDTH'(insn[62:49]);
    assign unused_insn_bits = ^{insn[6:0], insn[INS_WIDTH-1:F_TOP]};

    assign insn_ready = (state == S_IDLE) && !rst;
    assign accept     = insn_valid && insn_ready;
    assign degenerate = (d_out == '0) || (d_in == '0) || (d_end <= {1'b0, d_bgn});

    assign last_upc = (({1'b0, upc} + (UPC_WIDTH+1)'(1)) == end_q);
    assign last_in  = (i_in == iter_in_q - ITER_WIDTH'(1));
    assign last_out = (i_out == iter_out_q - ITER_WIDTH'(1));
    assign last_all = last_upc && last_in && last_out;

    assign acc_sum = ACC_OW'(uop[ACC_IDX_WIDTH-1:0]) + acc_off;
    assign inp_sum = INP_OW'(uop[ACC_IDX_WIDTH +: INP_IDX_WIDTH]) + inp_off;
    assign wgt_sum = WGT_OW'(uop[ACC_IDX_WIDTH+INP_IDX_WIDTH +: WGT_IDX_WIDTH]) + wgt_off;

    assign uop_rd_en = (state == S_FETCH);
    assign idx_valid = (state == S_EMIT);
    assign idx_last  = idx_valid && last_all;
    assign done      = (state == S_FIN);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = degenerate ? S_FIN : S_FETCH;
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_EMIT;
            S_EMIT:  if (idx_ready) state_nxt = last_all ? S_FIN : S_FETCH;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Instruction latch, loop counters, incremental offsets and index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bgn_q <= '0; end_q <= '0; iter_out_q <= '0; iter_in_q <= '0;
            i_out <= '0; i_in <= '0; upc <= '0; reset_acc <= 1'b0;
            f_acc_out <= '0; f_acc_in <= '0; f_inp_out <= '0; f_inp_in <= '0;
            f_wgt_out <= '0; f_wgt_in <= '0;
            acc_base <= '0; acc_off <= '0; inp_base <= '0; inp_off <= '0;
            wgt_base <= '0; wgt_off <= '0;
            acc_idx <= '0; inp_idx <= '0; wgt_idx <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    bgn_q      <= d_bgn;
                    end_q      <= d_end;
                    iter_out_q <= d_out;
                    iter_in_q  <= d_in;
                    reset_acc  <= insn[7];
                    f_acc_out  <= insn[F_DST_OUT +: ACC_IDX_WIDTH];
                    f_acc_in   <= insn[F_DST_IN  +: ACC_IDX_WIDTH];
                    f_inp_out  <= insn[F_SRC_OUT +: INP_IDX_WIDTH];
                    f_inp_in   <= insn[F_SRC_IN  +: INP_IDX_WIDTH];
                    f_wgt_out  <= insn[F_WGT_OUT +: WGT_IDX_WIDTH];
                    f_wgt_in   <= insn[F_WGT_IN  +: WGT_IDX_WIDTH];
                    upc <= d_bgn; i_out <= '0; i_in <= '0;
                    acc_base <= '0; acc_off <= '0; inp_base <= '0; inp_off <= '0;
                    wgt_base <= '0; wgt_off <= '0;
                end
                S_WAIT: begin
                    acc_idx <= acc_sum[ACC_IDX_WIDTH-1:0];
                    inp_idx <= inp_sum[INP_IDX_WIDTH-1:0];
                    wgt_idx <= wgt_sum[WGT_IDX_WIDTH-1:0];
                end
                S_EMIT: if (idx_ready) begin
                    if (!last_upc) begin
                        upc <= upc + UPC_WIDTH'(1);
                    end else begin
                        upc <= bgn_q;
                        if (!last_in) begin
                            i_in    <= i_in + ITER_WIDTH'(1);
                            acc_off <= acc_off + ACC_OW'(f_acc_in);
                            inp_off <= inp_off + INP_OW'(f_inp_in);
                            wgt_off <= wgt_off + WGT_OW'(f_wgt_in);
                        end else begin
                            i_in <= '0;
                            if (!last_out) begin
                                // Inner offset restarts from the advanced outer base.
                                i_out    <= i_out + ITER_WIDTH'(1);
                                acc_base <= acc_base + ACC_OW'(f_acc_out);
                                acc_off  <= acc_base + ACC_OW'(f_acc_out);
                                inp_base <= inp_base + INP_OW'(f_inp_out);
                                inp_off  <= inp_base + INP_OW'(f_inp_out);
                                wgt_base <= wgt_base + WGT_OW'(f_wgt_out);
                                wgt_off  <= wgt_base + WGT_OW'(f_wgt_out);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GEMM_IDX_BOUNDS_CHK_EN
    logic emit_err;

    // Sticky out-of-range flag for the current instruction and saturating error count.
    always_ff @(posedge clk) begin
        if (rst) begin
            emit_err     <= 1'b0;
            idx_err      <= 1'b0;
            err_insn_cnt <= '0;
        end else begin
            if (accept) idx_err <= 1'b0;
            if (state == S_WAIT)
                emit_err <= (acc_sum >= ACC_OW'(ACC_DEPTH_MAX)) ||
                            (inp_sum >= INP_OW'(INP_DEPTH_MAX)) ||
                            (wgt_sum >= WGT_OW'(WGT_DEPTH_MAX));
            if (state == S_EMIT && idx_ready && emit_err) idx_err <= 1'b1;
            if (state == S_FIN && idx_err && err_insn_cnt != 8'hFF)
                err_insn_cnt <= err_insn_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gemm_idx_gen.sv
// Self-checking bench for gemm_idx_gen: loop-nest model with a per-cycle
// compare process plus directed literal expectations per scenario.
module tb_gemm_idx_gen;

    logic         clk, rst, insn_valid, insn_ready, uop_rd_en;
    logic [127:0] insn;
    logic [12:0]  upc;
    logic [31:0]  uop;
    logic         idx_valid, idx_ready, reset_acc, idx_last, done;
    logic [10:0]  acc_idx, inp_idx;
    logic [9:0]   wgt_idx;
`ifdef GEMM_IDX_BOUNDS_CHK_EN
    logic         idx_err;
    logic [7:0]   err_insn_cnt;
`endif

    gemm_idx_gen dut (
        .clk(clk), .rst(rst), .insn_valid(insn_valid), .insn_ready(insn_ready),
        .insn(insn), .upc(upc), .uop_rd_en(uop_rd_en), .uop(uop),
        .idx_valid(idx_valid), .idx_ready(idx_ready), .acc_idx(acc_idx),
        .inp_idx(inp_idx), .wgt_idx(wgt_idx), .reset_acc(reset_acc),
        .idx_last(idx_last),
`ifdef GEMM_IDX_BOUNDS_CHK_EN
        .idx_err(idx_err), .err_insn_cnt(err_insn_cnt),
`endif
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // uop BRAM with one-cycle read latency
    logic [31:0] mem [0:7];
    always @(posedge clk) if (uop_rd_en) uop <= mem[upc[2:0]];

    typedef struct { int acc; int inp; int wgt; int last; int ra; } trip_t;
    trip_t exp_q[$];
    trip_t got_q[$];

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int vcnt   = 0;
    bit bp_mode = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_insn(input int ra, input int bgn, input int en,
                                             input int no, input int ni, input int dout,
                                             input int din, input int sout, input int sin,
                                             input int wout, input int win);
        logic [127:0] v;
        v = '0;
        v[7]       = ra[0];
        v[20:8]    = 13'(bgn);
        v[34:21]   = 14'(en);
        v[48:35]   = 14'(no);
        v[62:49]   = 14'(ni);
        v[73:63]   = 11'(dout);
        v[84:74]   = 11'(din);
        v[95:85]   = 11'(sout);
        v[106:96]  = 11'(sin);
        v[116:107] = 10'(wout);
        v[126:117] = 10'(win);
        return v;
    endfunction

    // Model: expand each accepted instruction into its full triple list; compare every cycle.
    bit exp_done = 0;
    bit p_valid = 0, p_ready = 0;
    int p_acc, p_inp, p_wgt, p_last;
    always @(negedge clk) begin
        bit nxt;
        int bgn, en, no, ni, dout, din, sout, sin, wout, win, ra;
        trip_t t, e;
        logic [31:0] w;
        if (rst) begin
            exp_done = 0;
            exp_q.delete();
            p_valid = 0;
        end else begin
            nxt = 0;
            chk("done", int'(done), int'(exp_done));
            if (uop_rd_en) rd_cnt++;
            if (idx_valid) vcnt++;
            if (p_valid && !p_ready) begin
                chk("hold_valid", int'(idx_valid), 1);
                chk("hold_acc", int'(acc_idx), p_acc);
                chk("hold_inp", int'(inp_idx), p_inp);
                chk("hold_wgt", int'(wgt_idx), p_wgt);
                chk("hold_last", int'(idx_last), p_last);
            end
            if (insn_valid && insn_ready) begin
                ra = int'(insn[7]);       bgn = int'(insn[20:8]);   en = int'(insn[34:21]);
                no = int'(insn[48:35]);   ni = int'(insn[62:49]);
                dout = int'(insn[73:63]); din = int'(insn[84:74]);
                sout = int'(insn[95:85]); sin = int'(insn[106:96]);
                wout = int'(insn[116:107]); win = int'(insn[126:117]);
                if (no == 0 || ni == 0 || en <= bgn) nxt = 1;
                else
                    for (int o = 0; o < no; o++)
                        for (int i = 0; i < ni; i++)
                            for (int u = bgn; u < en; u++) begin
                                w = mem[u % 8];
                                t.acc  = (int'(w[10:0])  + o*dout + i*din) % 2048;
                                t.inp  = (int'(w[21:11]) + o*sout + i*sin) % 2048;
                                t.wgt  = (int'(w[31:22]) + o*wout + i*win) % 1024;
                                t.last = (o == no-1 && i == ni-1 && u == en-1) ? 1 : 0;
                                t.ra   = ra;
                                exp_q.push_back(t);
                            end
            end
            if (idx_valid && idx_ready) begin
                t.acc = int'(acc_idx); t.inp = int'(inp_idx); t.wgt = int'(wgt_idx);
                t.last = int'(idx_last); t.ra = int'(reset_acc);
                got_q.push_back(t);
                if (exp_q.size() == 0) begin
                    chk("unexpected_triple", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("acc_idx", t.acc, e.acc);
                    chk("inp_idx", t.inp, e.inp);
                    chk("wgt_idx", t.wgt, e.wgt);
                    chk("idx_last", t.last, e.last);
                    chk("reset_acc", t.ra, e.ra);
                    if (e.last == 1) nxt = 1;
                end
            end
            p_valid = idx_valid; p_ready = idx_ready;
            p_acc = int'(acc_idx); p_inp = int'(inp_idx);
            p_wgt = int'(wgt_idx); p_last = int'(idx_last);
            exp_done = nxt;
        end
    end

    // Backpressure pattern driver
    initial begin
        logic [15:0] pat;
        int k;
        pat = 16'b1001_0110_1100_1001;
        k = 0;
        forever begin
            @(posedge clk); #1;
            if (bp_mode) begin
                idx_ready = pat[k % 16];
                k++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [127:0] v);
        int n;
        @(posedge clk); #1;
        insn = v; insn_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!insn_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        insn_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
        chk({nm, "_done_seen"}, int'(done === 1'b1), 1);
    endtask

    task automatic check_s2(input string nm);
        int ea[12] = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13};
        int ei[12] = '{0, 0, 1, 1, 2, 2, 4, 4, 5, 5, 6, 6};
        chk({nm, "_count"}, got_q.size(), 12);
        for (int i = 0; i < 12 && i < got_q.size(); i++) begin
            chk({nm, "_acc"}, got_q[i].acc, ea[i]);
            chk({nm, "_inp"}, got_q[i].inp, ei[i]);
            chk({nm, "_last"}, got_q[i].last, (i == 11) ? 1 : 0);
        end
    endtask

    logic [127:0] s2_insn;

    initial begin
        int n;
        rst = 1'b1; insn_valid = 1'b0; insn = '0; idx_ready = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        s2_insn = mk_insn(0, 0, 2, 2, 3, 8, 2, 4, 1, 0, 0);

        // reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_insn_ready_low", int'(insn_ready), 0);
        rst = 1'b0;
        #1;
        chk("rst_insn_ready", int'(insn_ready), 1);
        chk("rst_idx_valid", int'(idx_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_uop_rd_en", int'(uop_rd_en), 0);
        chk("rst_upc", int'(upc), 0);
        chk("rst_acc_idx", int'(acc_idx), 0);
        chk("rst_idx_last", int'(idx_last), 0);
        chk("rst_reset_acc", int'(reset_acc), 0);
`ifdef GEMM_IDX_BOUNDS_CHK_EN
        chk("rst_idx_err", int'(idx_err), 0);
        chk("rst_err_cnt", int'(err_insn_cnt), 0);
`endif

        // 1: smoke
        mem[0] = {10'd3, 11'd2, 11'd1};
        got_q.delete();
        send(mk_insn(1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        n = 1;
        while (!idx_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("s1_first_valid_latency", n, 3);
        wait_done("s1");
        chk("s1_ready_in_fin", int'(insn_ready), 0);
        chk("s1_count", got_q.size(), 1);
        if (got_q.size() > 0) begin
            chk("s1_acc", got_q[0].acc, 1);
            chk("s1_inp", got_q[0].inp, 2);
            chk("s1_wgt", got_q[0].wgt, 3);
            chk("s1_last", got_q[0].last, 1);
            chk("s1_reset_acc", got_q[0].ra, 1);
        end
        @(posedge clk); #1;
        chk("s1_ready_after", int'(insn_ready), 1);
        chk("s1_done_one_cycle", int'(done), 0);

        // 2: loop nest
        mem[0] = 32'd0; mem[1] = 32'd1;
        got_q.delete();
        send(s2_insn);
        wait_done("s2");
        check_s2("s2");

        // 3: backpressure
        got_q.delete();
        bp_mode = 1;
        send(s2_insn);
        wait_done("s3");
        bp_mode = 0;
        @(posedge clk); #1;
        idx_ready = 1'b1;
        check_s2("s3");

        // 4: degenerate loops
        for (int d = 0; d < 2; d++) begin
            rd_cnt = 0; vcnt = 0;
            if (d == 0) send(mk_insn(0, 0, 2, 2, 0, 1, 1, 1, 1, 1, 1));
            else        send(mk_insn(0, 5, 5, 1, 1, 0, 0, 0, 0, 0, 0));
            n = 1;
            while (!done && n < 20) begin @(posedge clk); #1; n++; end
            chk("s4_done_cycle", n, 1);
            repeat (3) @(posedge clk);
            #1;
            chk("s4_no_rd_en", rd_cnt, 0);
            chk("s4_no_valid", vcnt, 0);
        end

        // 5: reset mid-run during EMIT of triple 4
        got_q.delete();
        send(s2_insn);
        n = 0;
        while (got_q.size() < 3 && n < 100) begin @(posedge clk); #1; n++; end
        idx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("s5_in_emit", int'(idx_valid), 1);
        chk("s5_triple4_acc", int'(acc_idx), 3);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("s5_valid_after_rst", int'(idx_valid), 0);
        chk("s5_done_after_rst", int'(done), 0);
        chk("s5_acc_after_rst", int'(acc_idx), 0);
        rst = 1'b0;
        #1;
        chk("s5_ready_after_rst", int'(insn_ready), 1);
        repeat (4) @(posedge clk);
        #1;
        chk("s5_accepted_before_rst", got_q.size(), 3);
        idx_ready = 1'b1;
        got_q.delete();
        send(s2_insn);
        wait_done("s5b");
        check_s2("s5b");

        // 6: wrap and bounds
        mem[2] = {10'd0, 11'd0, 11'd2040};
        got_q.delete();
        send(mk_insn(0, 2, 3, 1, 3, 0, 4, 0, 0, 0, 0));
        n = 0;
        while (got_q.size() < 2 && n < 100) begin @(posedge clk); #1; n++; end
`ifdef GEMM_IDX_BOUNDS_CHK_EN
        chk("s6_err_before_3rd", int'(idx_err), 0);
`endif
        wait_done("s6");
        chk("s6_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("s6_acc0", got_q[0].acc, 2040);
            chk("s6_acc1", got_q[1].acc, 2044);
            chk("s6_acc2_wrap", got_q[2].acc, 0);
            chk("s6_last", got_q[2].last, 1);
        end
`ifdef GEMM_IDX_BOUNDS_CHK_EN
        chk("s6_idx_err", int'(idx_err), 1);
        @(posedge clk); #1;
        chk("s6_err_cnt", int'(err_insn_cnt), 1);
        mem[0] = {10'd3, 11'd2, 11'd1};
        send(mk_insn(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        chk("s6_err_cleared", int'(idx_err), 0);
        wait_done("s6b");
        @(posedge clk); #1;
        chk("s6b_err_clean", int'(idx_err), 0);
        chk("s6b_err_cnt", int'(err_insn_cnt), 1);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("model_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
